// File: rtl/forward_data_if.sv
// Forwarding-unit bus: hazard selects, pipeline data and forwarded results.
interface forward_data_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
);
  logic            stall;
  logic            rst_pipe;
  logic            hit_rs1_idex_ex;
  logic            hit_rs1_idma_ex;
  logic            hit_rs1_idwb_ex;
  logic            nohit_rs1_ex;
  logic            hit_rs2_idex_ex;
  logic            hit_rs2_idma_ex;
  logic            hit_rs2_idwb_ex;
  logic            nohit_rs2_ex;
  logic [XLEN-1:0] rs1_data_ex;
  logic [XLEN-1:0] rs2_data_ex;
  logic [XLEN-1:0] rd_data_ex;
  logic            cmd_ld_ma;
  logic [XLEN-1:0] ld_data_ma;
  logic            cnt_clr;
  logic [XLEN-1:0] rs1_fwd_ex;
  logic [XLEN-1:0] rs2_fwd_ex;
  logic [XLEN-1:0] rd_data_ma;
  logic [XLEN-1:0] wbk_data_wb;
  logic            sel_err;
  logic [CNTW-1:0] fwd_cnt;

  modport master (
    output stall, rst_pipe,
    output hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex,
    output hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex,
    output rs1_data_ex, rs2_data_ex, rd_data_ex, cmd_ld_ma, ld_data_ma, cnt_clr,
    input  rs1_fwd_ex, rs2_fwd_ex, rd_data_ma, wbk_data_wb, sel_err, fwd_cnt
  );

  modport slave (
    input  stall, rst_pipe,
    input  hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex,
    input  hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex,
    input  rs1_data_ex, rs2_data_ex, rd_data_ex, cmd_ld_ma, ld_data_ma, cnt_clr,
    output rs1_fwd_ex, rs2_fwd_ex, rd_data_ma, wbk_data_wb, sel_err, fwd_cnt
  );
endinterface

// File: rtl/forward_data.sv
// Operand forwarding for a 5-stage pipeline: holds the MA and WB result
// registers, muxes the newest available result into each EX operand, flags
// inconsistent select sets and counts forwarding events.
module forward_data #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input logic           clk,
  input logic           rst_n,
  forward_data_if.slave bus
);
  logic [XLEN-1:0] rd_data_ma_reg;
  logic [XLEN-1:0] wbk_data_wb_reg;
  logic [CNTW-1:0] fwd_cnt_reg;
  logic            sel_err_reg;
  logic [XLEN-1:0] ma_res;
  logic            any_hit;
  logic            any_bad;

  // A load in MA overrides the ALU result carried from EX.
  assign ma_res = bus.cmd_ld_ma ? bus.ld_data_ma : rd_data_ma_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic [2:0]      hit;      // {idex, idma, idwb}
    logic            nohit;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] fwd;
    logic            any;
    logic            bad;

    if (gi == 0) begin : g_rs1
      assign hit     = {bus.hit_rs1_idex_ex, bus.hit_rs1_idma_ex, bus.hit_rs1_idwb_ex};
      assign nohit   = bus.nohit_rs1_ex;
      assign rs_data = bus.rs1_data_ex;
    end else begin : g_rs2
      assign hit     = {bus.hit_rs2_idex_ex, bus.hit_rs2_idma_ex, bus.hit_rs2_idwb_ex};
      assign nohit   = bus.nohit_rs2_ex;
      assign rs_data = bus.rs2_data_ex;
    end

    // Newest-first operand mux; overlapping hits resolve to the youngest result.
    always_comb begin
      fwd = rs_data;
      if (hit[2])      fwd = rd_data_ma_reg;
      else if (hit[1]) fwd = ma_res;
      else if (hit[0]) fwd = wbk_data_wb_reg;
    end

    assign any = |hit;
    // nohit must be exactly the complement of "some hit".
    assign bad = (nohit == any);
  end

  assign any_hit = g_op[0].any | g_op[1].any;
  assign any_bad = g_op[0].bad | g_op[1].bad;

  // Pipeline result registers: flush beats stall, stall holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_ma_reg  <= '0;
      wbk_data_wb_reg <= '0;
    end else if (bus.rst_pipe) begin
      rd_data_ma_reg  <= '0;
      wbk_data_wb_reg <= '0;
    end else if (!bus.stall) begin
      rd_data_ma_reg  <= bus.rd_data_ex;
      wbk_data_wb_reg <= ma_res;
    end
  end

  // Saturating forward-event counter; clear overrides stall and increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_cnt_reg <= '0;
    end else if (bus.cnt_clr) begin
      fwd_cnt_reg <= '0;
    end else if (!bus.stall && any_hit && (fwd_cnt_reg != {CNTW{1'b1}})) begin
      fwd_cnt_reg <= fwd_cnt_reg + 1'b1;
    end
  end

  // Sticky select-consistency flag, only evaluated on advancing edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_reg <= 1'b0;
    end else if (!bus.stall && any_bad) begin
      sel_err_reg <= 1'b1;
    end
  end

  assign bus.rs1_fwd_ex  = g_op[0].fwd;
  assign bus.rs2_fwd_ex  = g_op[1].fwd;
  assign bus.rd_data_ma  = rd_data_ma_reg;
  assign bus.wbk_data_wb = wbk_data_wb_reg;
  assign bus.fwd_cnt     = fwd_cnt_reg;
  assign bus.sel_err     = sel_err_reg;
endmodule

// File: tb/tb_forward_data.sv
// Directed plus randomized check of forward_data against a behavioural model.
module tb_forward_data;
  localparam int XLEN = 32;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;

  // Reference model state
  logic [31:0] m_ma, m_wb;
  int          m_cnt;
  logic        m_err;

  forward_data_if #(.XLEN(XLEN), .CNTW(CNTW)) bus ();

  forward_data #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_ma_res();
    return bus.cmd_ld_ma ? bus.ld_data_ma : m_ma;
  endfunction

  // Youngest matching source wins: EX result, then MA result, then WB data.
  function automatic logic [31:0] m_pick(input logic [2:0] h, input logic [31:0] rs);
    logic [31:0] src [3];
    src[0] = m_ma;
    src[1] = m_ma_res();
    src[2] = m_wb;
    for (int i = 0; i < 3; i++)
      if (h[2-i]) return src[i];
    return rs;
  endfunction

  function automatic logic [2:0] hits1();
    return {bus.hit_rs1_idex_ex, bus.hit_rs1_idma_ex, bus.hit_rs1_idwb_ex};
  endfunction

  function automatic logic [2:0] hits2();
    return {bus.hit_rs2_idex_ex, bus.hit_rs2_idma_ex, bus.hit_rs2_idwb_ex};
  endfunction

  task automatic set_rs1(input logic [2:0] h, input logic nh);
    {bus.hit_rs1_idex_ex, bus.hit_rs1_idma_ex, bus.hit_rs1_idwb_ex} = h;
    bus.nohit_rs1_ex = nh;
  endtask

  task automatic set_rs2(input logic [2:0] h, input logic nh);
    {bus.hit_rs2_idex_ex, bus.hit_rs2_idma_ex, bus.hit_rs2_idwb_ex} = h;
    bus.nohit_rs2_ex = nh;
  endtask

  // Combinational outputs, checked mid-cycle before the edge.
  task automatic settle();
    @(negedge clk);
    chk("rs1_fwd", bus.rs1_fwd_ex, m_pick(hits1(), bus.rs1_data_ex));
    chk("rs2_fwd", bus.rs2_fwd_ex, m_pick(hits2(), bus.rs2_data_ex));
  endtask

  // One rising edge: advance the model, then check the registered outputs.
  task automatic tick();
    logic [31:0] nres;
    logic        any, bad;
    nres = m_ma_res();
    any  = (|hits1()) || (|hits2());
    bad  = (bus.nohit_rs1_ex == (|hits1())) || (bus.nohit_rs2_ex == (|hits2()));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_ma = '0; m_wb = '0; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (bus.rst_pipe) begin
        m_ma = '0; m_wb = '0;
      end else if (!bus.stall) begin
        m_wb = nres; m_ma = bus.rd_data_ex;
      end
      if (bus.cnt_clr) m_cnt = 0;
      else if (!bus.stall && any && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (!bus.stall && bad) m_err = 1'b1;
    end
    cyc++;
    $display("cyc %0d rst_n=%b stall=%b pipe=%b clr=%b ma=%h wb=%h cnt=%0d err=%b",
             cyc, rst_n, bus.stall, bus.rst_pipe, bus.cnt_clr,
             bus.rd_data_ma, bus.wbk_data_wb, bus.fwd_cnt, bus.sel_err);
    chk("rd_data_ma", bus.rd_data_ma, m_ma);
    chk("wbk_data_wb", bus.wbk_data_wb, m_wb);
    chk("fwd_cnt", {28'b0, bus.fwd_cnt}, m_cnt[31:0]);
    chk("sel_err", {31'b0, bus.sel_err}, {31'b0, m_err});
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    logic [31:0] sv_ma, sv_wb, sv_cnt;
    vectors = 0; miscompares = 0; cyc = 0;
    m_ma = '0; m_wb = '0; m_cnt = 0; m_err = 1'b0;
    rst_n = 1'b0;
    bus.stall = 0; bus.rst_pipe = 0; bus.cnt_clr = 0; bus.cmd_ld_ma = 0;
    bus.rs1_data_ex = 32'h1111_0001; bus.rs2_data_ex = 32'h2222_0002;
    bus.rd_data_ex = 32'h5555_AAAA; bus.ld_data_ma = 32'h0;
    set_rs1(3'b000, 1'b1); set_rs2(3'b000, 1'b1);
    step(); step();
    chk("reset_ma", bus.rd_data_ma, 32'h0);
    chk("reset_cnt", {28'b0, bus.fwd_cnt}, 32'h0);
    settle();
    chk("reset_rs1_pass", bus.rs1_fwd_ex, 32'h1111_0001);
    chk("reset_rs2_pass", bus.rs2_fwd_ex, 32'h2222_0002);

    // EX-to-EX
    rst_n = 1'b1;
    bus.rd_data_ex = 32'h11;
    tick();
    set_rs1(3'b100, 1'b0);
    bus.rd_data_ex = 32'h99;
    settle();
    chk("ex2ex", bus.rs1_fwd_ex, 32'h11);
    tick();

    // Load-use
    set_rs1(3'b000, 1'b1);
    bus.rd_data_ex = 32'h5;
    step();
    bus.cmd_ld_ma = 1; bus.ld_data_ma = 32'hDEADBEEF;
    set_rs2(3'b010, 1'b0);
    settle();
    chk("load_use_fwd", bus.rs2_fwd_ex, 32'hDEADBEEF);
    tick();
    chk("load_use_wb", bus.wbk_data_wb, 32'hDEADBEEF);

    // Priority with all three hits
    bus.cmd_ld_ma = 0; set_rs2(3'b000, 1'b1);
    bus.rd_data_ex = 32'hC; step();
    bus.rd_data_ex = 32'hA; step();
    bus.cmd_ld_ma = 1; bus.ld_data_ma = 32'hB; bus.rd_data_ex = 32'h0;
    set_rs1(3'b111, 1'b0);
    settle();
    chk("prio_rs1", bus.rs1_fwd_ex, 32'hA);
    sv_cnt = {28'b0, bus.fwd_cnt};
    tick();
    chk("prio_cnt", {28'b0, bus.fwd_cnt}, sv_cnt + 1);
    chk("prio_err", {31'b0, bus.sel_err}, 32'h0);

    // Stall hold, then flush during stall
    bus.cmd_ld_ma = 0; set_rs1(3'b001, 1'b0);
    bus.rd_data_ex = 32'h77; step();
    sv_ma = bus.rd_data_ma; sv_wb = bus.wbk_data_wb; sv_cnt = {28'b0, bus.fwd_cnt};
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.rd_data_ex = $urandom;
      step();
    end
    chk("stall_ma", bus.rd_data_ma, sv_ma);
    chk("stall_wb", bus.wbk_data_wb, sv_wb);
    chk("stall_cnt", {28'b0, bus.fwd_cnt}, sv_cnt);
    bus.rst_pipe = 1; step();
    chk("flush_ma", bus.rd_data_ma, 32'h0);
    chk("flush_wb", bus.wbk_data_wb, 32'h0);
    bus.stall = 0; bus.rst_pipe = 0;

    // Select error is sticky
    set_rs1(3'b001, 1'b1); step();
    chk("sel_err_set", {31'b0, bus.sel_err}, 32'h1);
    set_rs1(3'b000, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("sel_err_sticky", {31'b0, bus.sel_err}, 32'h1);

    // Counter saturation and clear
    set_rs2(3'b100, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.rd_data_ex = $urandom; step();
    end
    chk("cnt_sat", {28'b0, bus.fwd_cnt}, 32'hF);
    bus.cnt_clr = 1; bus.stall = 1; step();
    chk("cnt_clr", {28'b0, bus.fwd_cnt}, 32'h0);
    bus.cnt_clr = 0; bus.stall = 0;

    // Randomized traffic with occasional resets, flushes and bad selects
    for (int i = 0; i < 300; i++) begin
      logic [2:0] h1, h2;
      h1 = 3'($urandom_range(0, 7));
      h2 = 3'($urandom_range(0, 7));
      set_rs1(h1, ($urandom_range(0, 19) == 0) ? (|h1) : !(|h1));
      set_rs2(h2, ($urandom_range(0, 19) == 0) ? (|h2) : !(|h2));
      rst_n          = ($urandom_range(0, 29) != 0);
      bus.stall      = ($urandom_range(0, 4) == 0);
      bus.rst_pipe   = ($urandom_range(0, 14) == 0);
      bus.cnt_clr    = ($urandom_range(0, 24) == 0);
      bus.cmd_ld_ma  = $urandom_range(0, 1) != 0;
      bus.rs1_data_ex = $urandom; bus.rs2_data_ex = $urandom;
      bus.rd_data_ex  = $urandom; bus.ld_data_ma  = $urandom;
      step();
    end

    // Reset mid-operation while stalled
    rst_n = 1; bus.stall = 0; bus.rst_pipe = 0; bus.cnt_clr = 0;
    set_rs1(3'b010, 1'b1); set_rs2(3'b100, 1'b0);
    bus.rd_data_ex = 32'hFACE; step(); step();
    bus.stall = 1; rst_n = 0; step();
    chk("rst_mid_ma", bus.rd_data_ma, 32'h0);
    chk("rst_mid_wb", bus.wbk_data_wb, 32'h0);
    chk("rst_mid_cnt", {28'b0, bus.fwd_cnt}, 32'h0);
    chk("rst_mid_err", {31'b0, bus.sel_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
